// File: rtl/debug_unit_ctrl.sv
// Debug controller for the pipelined MIPS DataPath.
// Decodes UART command bytes, gates the CPU clock enable (run / step / reset)
// and streams a state dump (DUMP_WORDS dump-bus words, then the cycle count)
// back through the UART transmitter, MSB first.
module debug_unit_ctrl #(
  parameter int unsigned DUMP_WORDS = 33,
  parameter logic [7:0]  CMD_RUN    = 8'h63,
  parameter logic [7:0]  CMD_STEP   = 8'h73,
  parameter logic [7:0]  CMD_RESET  = 8'h72,
  parameter logic [7:0]  CMD_DUMP   = 8'h64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_done,
  input  logic        tx_done,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  input  logic        cpu_halt,
  output logic        cpu_enable,
  output logic        cpu_reset,
  output logic [5:0]  dump_addr,
  input  logic [31:0] dump_data,
  output logic        busy
);

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned IDX_W  = 6;
  localparam int unsigned BIDX_W = 2;

  // Index of the pseudo-word that carries the cycle counter.
  localparam logic [IDX_W-1:0] LAST_WORD = IDX_W'(DUMP_WORDS);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RUN    = 3'd1,
    STEP   = 3'd2,
    CPURST = 3'd3,
    DLOAD  = 3'd4,
    DSEND  = 3'd5,
    DWAIT  = 3'd6
  } state_e;

  state_e              state_q,      state_d;
  logic [IDX_W-1:0]    word_idx_q,   word_idx_d;
  logic [BIDX_W-1:0]   byte_idx_q,   byte_idx_d;
  logic [WORD_W-1:0]   shift_q,      shift_d;
  logic [WORD_W-1:0]   cycle_cnt_q,  cycle_cnt_d;
  logic                load_wait_q,  load_wait_d;
  logic                rst_cnt_q,    rst_cnt_d;
  logic                tx_start_q,   tx_start_d;
  logic [BYTE_W-1:0]   tx_data_q,    tx_data_d;
  logic                cpu_enable_q, cpu_enable_d;
  logic                cpu_reset_q,  cpu_reset_d;
  logic [IDX_W-1:0]    dump_addr_q,  dump_addr_d;
  logic                busy_q,       busy_d;

  // State and output registers; synchronous reset aborts any activity.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      word_idx_q   <= '0;
      byte_idx_q   <= '0;
      shift_q      <= '0;
      cycle_cnt_q  <= '0;
      load_wait_q  <= 1'b0;
      rst_cnt_q    <= 1'b0;
      tx_start_q   <= 1'b0;
      tx_data_q    <= '0;
      cpu_enable_q <= 1'b0;
      cpu_reset_q  <= 1'b0;
      dump_addr_q  <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      word_idx_q   <= word_idx_d;
      byte_idx_q   <= byte_idx_d;
      shift_q      <= shift_d;
      cycle_cnt_q  <= cycle_cnt_d;
      load_wait_q  <= load_wait_d;
      rst_cnt_q    <= rst_cnt_d;
      tx_start_q   <= tx_start_d;
      tx_data_q    <= tx_data_d;
      cpu_enable_q <= cpu_enable_d;
      cpu_reset_q  <= cpu_reset_d;
      dump_addr_q  <= dump_addr_d;
      busy_q       <= busy_d;
    end
  end

  // Next-state and next-output logic. cpu_enable/cpu_reset are computed one
  // cycle ahead so the registered versions line up with RUN/STEP/CPURST.
  always_comb begin
    state_d      = state_q;
    word_idx_d   = word_idx_q;
    byte_idx_d   = byte_idx_q;
    shift_d      = shift_q;
    load_wait_d  = load_wait_q;
    rst_cnt_d    = rst_cnt_q;
    tx_start_d   = 1'b0;
    tx_data_d    = tx_data_q;
    cpu_enable_d = 1'b0;
    cpu_reset_d  = 1'b0;
    dump_addr_d  = dump_addr_q;

    // Every cycle the pipeline was enabled counts; wraps silently.
    cycle_cnt_d  = cpu_enable_q ? cycle_cnt_q + WORD_W'(1) : cycle_cnt_q;

    case (state_q)
      IDLE: begin
        load_wait_d = 1'b0;
        if (rx_done) begin
          case (rx_data)
            CMD_RUN: begin
              state_d      = RUN;
              // Already halted: enter RUN without a single enabled cycle.
              cpu_enable_d = ~cpu_halt;
            end
            CMD_STEP: begin
              state_d      = STEP;
              cpu_enable_d = 1'b1;
            end
            CMD_RESET: begin
              state_d     = CPURST;
              cpu_reset_d = 1'b1;
              rst_cnt_d   = 1'b0;
            end
            CMD_DUMP: begin
              state_d    = DLOAD;
              word_idx_d = '0;
            end
            default: ;
          endcase
        end
      end

      RUN: begin
        if (cpu_halt) begin
          state_d    = DLOAD;
          word_idx_d = '0;
        end else begin
          cpu_enable_d = 1'b1;
        end
      end

      STEP: begin
        state_d    = DLOAD;
        word_idx_d = '0;
      end

      CPURST: begin
        cycle_cnt_d = '0;
        if (!rst_cnt_q) begin
          cpu_reset_d = 1'b1;
          rst_cnt_d   = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end

      DLOAD: begin
        // First cycle lets the dump bus settle; second cycle captures.
        if (!load_wait_q) begin
          load_wait_d = 1'b1;
        end else begin
          load_wait_d = 1'b0;
          shift_d     = (word_idx_q == LAST_WORD) ? cycle_cnt_q : dump_data;
          byte_idx_d  = '0;
          state_d     = DSEND;
        end
      end

      DSEND: begin
        tx_start_d = 1'b1;
        tx_data_d  = shift_q[WORD_W-1 -: BYTE_W];
        state_d    = DWAIT;
      end

      DWAIT: begin
        if (tx_done) begin
          shift_d = {shift_q[WORD_W-BYTE_W-1:0], BYTE_W'(0)};
          if (byte_idx_q != BIDX_W'(3)) begin
            byte_idx_d = byte_idx_q + BIDX_W'(1);
            state_d    = DSEND;
          end else if (word_idx_q < LAST_WORD) begin
            word_idx_d = word_idx_q + IDX_W'(1);
            state_d    = DLOAD;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    // Present the word select as DLOAD is entered so data is ready a cycle later.
    if (state_d == DLOAD && state_q != DLOAD) begin
      dump_addr_d = word_idx_d;
    end

    busy_d = (state_d != IDLE);
  end

  assign tx_start   = tx_start_q;
  assign tx_data    = tx_data_q;
  assign cpu_enable = cpu_enable_q;
  assign cpu_reset  = cpu_reset_q;
  assign dump_addr  = dump_addr_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_debug_unit_ctrl.sv
// Testbench for debug_unit_ctrl: expected dump bytes are queued when a command
// is issued and popped as the DUT emits tx_start.
module tb_debug_unit_ctrl;

  localparam logic [7:0] C_RUN   = 8'h63;
  localparam logic [7:0] C_STEP  = 8'h73;
  localparam logic [7:0] C_RESET = 8'h72;
  localparam logic [7:0] C_DUMP  = 8'h64;
  localparam int         BUDGET  = 5000;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_done;
  logic        tx_done;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        cpu_halt;
  logic        cpu_enable;
  logic        cpu_reset;
  logic [5:0]  dump_addr;
  logic [31:0] dump_data;
  logic        busy;

  int          checks = 0;
  int          errors = 0;
  int          tx_count = 0;
  int          en_count = 0;
  int          rst_count = 0;
  logic [31:0] model_cnt = 32'd0;
  logic [7:0]  exp_q[$];
  logic [7:0]  mon_exp;

  logic        tx_busy;
  int          tx_cnt;

  debug_unit_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_done    (rx_done),
    .tx_done    (tx_done),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .cpu_halt   (cpu_halt),
    .cpu_enable (cpu_enable),
    .cpu_reset  (cpu_reset),
    .dump_addr  (dump_addr),
    .dump_data  (dump_data),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Dump bus model: word n = 0x1000_0000 + n, one cycle after the address.
  always @(posedge clk) dump_data <= 32'h1000_0000 + 32'(dump_addr);

  // UART transmitter model: tx_done pulse a few cycles after tx_start.
  always @(posedge clk) begin
    tx_done <= 1'b0;
    if (reset) begin
      tx_busy <= 1'b0;
      tx_cnt  <= 0;
    end else if (tx_start) begin
      tx_busy <= 1'b1;
      tx_cnt  <= 3;
    end else if (tx_busy) begin
      if (tx_cnt == 0) begin
        tx_done <= 1'b1;
        tx_busy <= 1'b0;
      end else begin
        tx_cnt <= tx_cnt - 1;
      end
    end
  end

  // Scoreboard and activity monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (tx_start === 1'b1) begin
      checks++;
      tx_count++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL tx_unexpected byte=%h want no transmission", tx_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (tx_data !== mon_exp) begin
          errors++;
          $display("FAIL tx_byte #%0d got %h want %h", tx_count - 1, tx_data, mon_exp);
        end
      end
    end
    if (cpu_enable === 1'b1) en_count++;
    if (cpu_reset === 1'b1) rst_count++;
    if (reset === 1'b0) begin
      checks++;
      if (cpu_enable === 1'b1 && cpu_reset === 1'b1) begin
        errors++;
        $display("FAIL en_rst_excl got enable=1 reset=1 want not both");
      end
    end
  end

  task automatic push_word(input logic [31:0] w);
    for (int b = 3; b >= 0; b--) exp_q.push_back(w[8*b +: 8]);
  endtask

  task automatic push_dump(input logic [31:0] cnt);
    for (int n = 0; n < 33; n++) push_word(32'h1000_0000 + 32'(n));
    push_word(cnt);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while ((busy !== 1'b0 || exp_q.size() != 0) && k < BUDGET) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (k >= BUDGET) begin
      errors++;
      $display("FAIL %s_timeout busy=%b pending=%0d want idle with 0 pending",
               name, busy, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    int t0;
    logic busy_seen;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({tx_start, tx_data, cpu_enable, cpu_reset, dump_addr, busy} !== 18'd0) begin
      errors++;
      $display("FAIL reset_outputs got st=%b td=%h en=%b rs=%b da=%h busy=%b want all 0",
               tx_start, tx_data, cpu_enable, cpu_reset, dump_addr, busy);
    end
    reset = 1'b0;
    t0 = tx_count;
    busy_seen = 1'b0;
    send_byte(8'h41);
    repeat (10) begin
      @(negedge clk);
      if (busy !== 1'b0) busy_seen = 1'b1;
    end
    checks++;
    if (busy_seen !== 1'b0) begin
      errors++;
      $display("FAIL unknown_cmd_busy got busy=1 want 0");
    end
    checks++;
    if (tx_count != t0) begin
      errors++;
      $display("FAIL unknown_cmd_tx got %0d bytes want 0", tx_count - t0);
    end
  endtask

  task automatic test_dump();
    int t0 = tx_count;
    push_dump(model_cnt);
    send_byte(C_DUMP);
    wait_idle("dump");
    checks++;
    if (tx_count - t0 != 136) begin
      errors++;
      $display("FAIL dump_len got %0d want 136", tx_count - t0);
    end
  endtask

  task automatic test_step();
    for (int s = 0; s < 3; s++) begin
      int e0 = en_count;
      model_cnt = model_cnt + 32'd1;
      push_dump(model_cnt);
      send_byte(C_STEP);
      wait_idle("step");
      checks++;
      if (en_count - e0 != 1) begin
        errors++;
        $display("FAIL step_enable #%0d got %0d cycles want 1", s, en_count - e0);
      end
    end
  endtask

  task automatic test_run();
    int e0 = en_count;
    int t0 = tx_count;
    int k = 0;
    model_cnt = model_cnt + 32'd50;
    push_dump(model_cnt);
    send_byte(C_RUN);
    repeat (49) @(negedge clk);
    cpu_halt = 1'b1;
    while (tx_count < t0 + 20 && k < BUDGET) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (k >= BUDGET) begin
      errors++;
      $display("FAIL run_dump_start got %0d bytes want >=20", tx_count - t0);
    end
    send_byte(C_STEP);
    wait_idle("run");
    repeat (20) @(negedge clk);
    checks++;
    if (en_count - e0 != 50) begin
      errors++;
      $display("FAIL run_enable got %0d cycles want 50", en_count - e0);
    end
    checks++;
    if (tx_count - t0 != 136 || busy !== 1'b0) begin
      errors++;
      $display("FAIL run_extra_cmd got %0d bytes busy=%b want 136 busy=0",
               tx_count - t0, busy);
    end
    cpu_halt = 1'b0;
  endtask

  task automatic test_run_halted();
    int e0 = en_count;
    cpu_halt = 1'b1;
    push_dump(model_cnt);
    send_byte(C_RUN);
    wait_idle("run_halted");
    cpu_halt = 1'b0;
    checks++;
    if (en_count != e0) begin
      errors++;
      $display("FAIL run_halted_enable got %0d cycles want 0", en_count - e0);
    end
  endtask

  task automatic test_cpu_reset();
    int t0 = tx_count;
    int r0 = rst_count;
    send_byte(C_RESET);
    repeat (10) @(negedge clk);
    checks++;
    if (rst_count - r0 != 2) begin
      errors++;
      $display("FAIL cpurst_len got %0d cycles want 2", rst_count - r0);
    end
    checks++;
    if (tx_count != t0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL cpurst_quiet got %0d bytes busy=%b want 0 bytes busy=0",
               tx_count - t0, busy);
    end
    model_cnt = 32'd0;
    test_dump();
  endtask

  task automatic test_abort();
    int t0 = tx_count;
    int k = 0;
    push_dump(model_cnt);
    send_byte(C_DUMP);
    while (tx_count < t0 + 11 && k < BUDGET) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (k >= BUDGET) begin
      errors++;
      $display("FAIL abort_reach got %0d bytes want 11", tx_count - t0);
    end
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    checks++;
    if ({tx_start, busy, cpu_enable, cpu_reset, dump_addr} !== 10'd0) begin
      errors++;
      $display("FAIL abort_state got st=%b busy=%b en=%b rs=%b da=%h want all 0",
               tx_start, busy, cpu_enable, cpu_reset, dump_addr);
    end
    reset = 1'b0;
    model_cnt = 32'd0;
    test_dump();
  endtask

  initial begin
    reset    = 1'b1;
    rx_data  = 8'h00;
    rx_done  = 1'b0;
    cpu_halt = 1'b0;
    test_reset();
    test_dump();
    test_step();
    test_run();
    test_run_halted();
    test_cpu_reset();
    test_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
